// File: rtl/buff_desc_pkg.sv
// Shared types and constants for the buff-description overlay.
package buff_desc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        SHOW = 2'd2
    } state_e;

    typedef logic [1:0] buff_type_t;

    localparam buff_type_t BUFF_ATK  = 2'd0;
    localparam buff_type_t BUFF_DEF  = 2'd1;
    localparam buff_type_t BUFF_HEAL = 2'd2;

    localparam int DESC_W_DEF = 92;
    localparam int DESC_H_DEF = 42;

    // Black pixels in the sprite ROM are see-through.
    localparam logic [23:0] TRANSPARENT_RGB = 24'h000000;

    // Only three sprites exist in the ROM; anything above the last one maps to it.
    function automatic buff_type_t clamp_type(input buff_type_t t);
        return (t > BUFF_HEAL) ? BUFF_HEAL : t;
    endfunction

endpackage

// File: rtl/buff_desc_ctrl_if.sv
// Request, scan, ROM and overlay signals of the buff-description panel.
interface buff_desc_ctrl_if;
    import buff_desc_pkg::*;

    logic        req_valid;
    buff_type_t  req_buff_type;
    logic        req_ready;
    logic        cancel;
    logic        frame_start;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic [6:0]  rom_x;
    logic [6:0]  rom_y;
    buff_type_t  rom_type;
    logic [23:0] rom_data;
    logic        out_valid;
    logic [23:0] out_rgb;
    logic        busy;

    modport slave (
        input  req_valid, req_buff_type, cancel, frame_start, pix_x, pix_y, rom_data,
        output req_ready, rom_x, rom_y, rom_type, out_valid, out_rgb, busy
    );

    modport master (
        output req_valid, req_buff_type, cancel, frame_start, pix_x, pix_y, rom_data,
        input  req_ready, rom_x, rom_y, rom_type, out_valid, out_rgb, busy
    );

endinterface

// File: rtl/buff_desc_align.sv
// Delays a pixel-valid flag by the ROM read latency; flush drops in-flight pixels.
module buff_desc_align #(
    parameter int LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    input  logic in_vld,
    output logic out_vld
);

    logic [LAT-1:0] vld_q, vld_d;

    // Shift in the new flag; a flush empties the whole line on the same edge.
    always_comb begin
        vld_d    = vld_q << 1;
        vld_d[0] = in_vld;
        if (flush) vld_d = '0;
    end

    // Valid line register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_q <= '0;
        else        vld_q <= vld_d;
    end

    assign out_vld = vld_q[LAT-1];

endmodule

// File: rtl/buff_desc_ctrl.sv
// Buff-description panel sequencer: waits for a frame boundary, shows the
// chosen sprite for HOLD_FRAMES frames and overlays it on the VGA scan.
module buff_desc_ctrl
    import buff_desc_pkg::*;
#(
    parameter int PANEL_X0    = 274,
    parameter int PANEL_Y0    = 200,
    parameter int DESC_W      = DESC_W_DEF,
    parameter int DESC_H      = DESC_H_DEF,
    parameter int HOLD_FRAMES = 120,
    parameter int ROM_LAT     = 1
) (
    input  logic             vga_clk,
    input  logic             rst_n,
    buff_desc_ctrl_if.slave  bus
);

    localparam int CNT_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
    localparam logic [CNT_W-1:0] LAST_FRAME = CNT_W'(HOLD_FRAMES - 1);

    // 11-bit bounds so the right/bottom limits never wrap against a 10-bit scan.
    localparam logic [10:0] X_LO = 11'(PANEL_X0);
    localparam logic [10:0] X_HI = 11'(PANEL_X0 + DESC_W);
    localparam logic [10:0] Y_LO = 11'(PANEL_Y0);
    localparam logic [10:0] Y_HI = 11'(PANEL_Y0 + DESC_H);

    state_e           state_q, state_d;
    buff_type_t       type_q, type_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic             hit_c;
    logic             hit_aligned;

    assign bus.req_ready = (state_q == IDLE) && !bus.cancel;
    assign bus.busy      = (state_q != IDLE);

    // Sequencing: accept, wait for a frame edge, count whole frames; cancel wins.
    always_comb begin
        state_d     = state_q;
        type_d      = type_q;
        frame_cnt_d = frame_cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid && bus.req_ready) begin
                    type_d  = clamp_type(bus.req_buff_type);
                    state_d = ARM;
                end
            end
            ARM: begin
                if (bus.cancel) begin
                    state_d = IDLE;
                end else if (bus.frame_start) begin
                    state_d     = SHOW;
                    frame_cnt_d = '0;
                end
            end
            SHOW: begin
                if (bus.cancel) begin
                    state_d = IDLE;
                end else if (bus.frame_start) begin
                    if (frame_cnt_q == LAST_FRAME) state_d = IDLE;
                    else                           frame_cnt_d = frame_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state registers.
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            type_q      <= BUFF_ATK;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            type_q      <= type_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Panel hit test on the current scan position.
    always_comb begin
        hit_c = (state_q == SHOW)
             && ({1'b0, bus.pix_x} >= X_LO) && ({1'b0, bus.pix_x} < X_HI)
             && ({1'b0, bus.pix_y} >= Y_LO) && ({1'b0, bus.pix_y} < Y_HI);
    end

    // Sprite-relative address; only meaningful while hit_c is high.
    assign bus.rom_x    = 7'(bus.pix_x - 10'(PANEL_X0));
    assign bus.rom_y    = 7'(bus.pix_y - 10'(PANEL_Y0));
    assign bus.rom_type = type_q;

    buff_desc_align #(.LAT(ROM_LAT)) u_align (
        .clk     (vga_clk),
        .rst_n   (rst_n),
        .flush   (bus.cancel),
        .in_vld  (hit_c),
        .out_vld (hit_aligned)
    );

    assign bus.out_valid = hit_aligned && (bus.rom_data != TRANSPARENT_RGB);
    assign bus.out_rgb   = bus.out_valid ? bus.rom_data : TRANSPARENT_RGB;

endmodule

// File: tb/tb_buff_desc_ctrl.sv
// Directed bench for buff_desc_ctrl with a frame-level reference model.
module tb_buff_desc_ctrl;

    localparam int HOLD = 3;
    localparam int LAT  = 1;

    logic vga_clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    buff_desc_ctrl_if bus();

    buff_desc_ctrl #(
        .PANEL_X0(274), .PANEL_Y0(200), .DESC_W(92), .DESC_H(42),
        .HOLD_FRAMES(HOLD), .ROM_LAT(LAT)
    ) dut (
        .vga_clk (vga_clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // phase: 0 nothing pending, 1 waiting for a frame, 2 on screen
    int              m_phase;
    int              m_left;     // frame boundaries still to pass before hiding
    logic [1:0]      m_type;
    logic [LAT:0]    m_sh;       // history of panel hits, newest in bit 0
    logic            e_hit;
    logic            e_valid;

    function automatic logic in_rect(input logic [9:0] x, input logic [9:0] y);
        return (x >= 10'd274) && (x <= 10'd365) && (y >= 10'd200) && (y <= 10'd241);
    endfunction

    always_comb begin
        e_hit   = (m_phase == 2) && in_rect(bus.pix_x, bus.pix_y);
        e_valid = m_sh[LAT-1] && (bus.rom_data != 24'h0);
    end

    always @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_left  <= 0;
            m_type  <= 2'd0;
            m_sh    <= '0;
        end else begin
            m_sh <= bus.cancel ? '0 : {m_sh[LAT-1:0], e_hit};
            if (m_phase == 0) begin
                if (bus.req_valid && !bus.cancel) begin
                    m_type  <= (bus.req_buff_type == 2'd3) ? 2'd2 : bus.req_buff_type;
                    m_phase <= 1;
                end
            end else if (bus.cancel) begin
                m_phase <= 0;
            end else if (bus.frame_start) begin
                if (m_phase == 1) begin
                    m_phase <= 2;
                    m_left  <= HOLD;
                end else if (m_left == 1) begin
                    m_phase <= 0;
                end else begin
                    m_left <= m_left - 1;
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge vga_clk) begin
        if (rst_n) begin
            chk("busy",      bus.busy,      m_phase != 0);
            chk("req_ready", bus.req_ready, (m_phase == 0) && !bus.cancel);
            chk("rom_type",  bus.rom_type,  m_type);
            chk("out_valid", bus.out_valid, e_valid);
            chk("out_rgb",   bus.out_rgb,   e_valid ? bus.rom_data : 24'h0);
            if (e_hit) begin
                chk("rom_x", bus.rom_x, (bus.pix_x - 10'd274) & 10'h7f);
                chk("rom_y", bus.rom_y, (bus.pix_y - 10'd200) & 10'h7f);
            end
        end
    end

    // ---------------- stimulus ----------------
    typedef struct {
        int          x;
        int          y;
        logic [23:0] rgb;
    } pt_t;
    pt_t pts[12];

    task automatic tick();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic set_pix(input int x, input int y, input logic [23:0] rgb);
        bus.pix_x    = 10'(x);
        bus.pix_y    = 10'(y);
        bus.rom_data = rgb;
    endtask

    task automatic scan_points();
        for (int i = 0; i < 12; i++) begin
            set_pix(pts[i].x, pts[i].y, pts[i].rgb);
            tick();
        end
        set_pix(0, 0, 24'h0);
        tick();
    endtask

    task automatic frame();
        bus.frame_start = 1'b1;
        set_pix(0, 0, 24'h0);
        tick();
        bus.frame_start = 1'b0;
        scan_points();
    endtask

    initial begin
        pts = '{'{274, 200, 24'h111111}, '{300, 220, 24'h222222}, '{365, 241, 24'h333333},
                '{273, 220, 24'h444444}, '{366, 220, 24'h555555}, '{300, 199, 24'h666666},
                '{300, 242, 24'h777777}, '{320, 220, 24'h888888}, '{320, 221, 24'h000000},
                '{274, 241, 24'h999999}, '{365, 200, 24'hAAAAAA}, '{10,  10,  24'hBBBBBB}};
        rst_n             = 1'b0;
        bus.req_valid     = 1'b0;
        bus.req_buff_type = 2'd0;
        bus.cancel        = 1'b0;
        bus.frame_start   = 1'b0;
        set_pix(0, 0, 24'h0);
        #2;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_rgb",   bus.out_rgb,   0);
        chk("rst_busy",      bus.busy,      0);
        chk("rst_req_ready", bus.req_ready, 1);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Accept type 1, nothing shown before a frame boundary.
        bus.req_valid = 1'b1; bus.req_buff_type = 2'd1;
        #1 chk("t1_ready", bus.req_ready, 1);
        tick();
        bus.req_valid = 1'b0;
        #1 chk("t1_busy", bus.busy, 1);
        chk("t1_type", bus.rom_type, 1);
        set_pix(300, 210, 24'hABCDEF);
        repeat (3) begin
            tick();
            #1 chk("t1_no_pix_armed", bus.out_valid, 0);
        end
        bus.cancel = 1'b1;
        tick();
        bus.cancel = 1'b0;
        #1 chk("t1_cancel_idle", bus.busy, 0);

        // Type 0 for HOLD frames, then hidden on the following boundary.
        bus.req_valid = 1'b1; bus.req_buff_type = 2'd0;
        tick();
        bus.req_valid   = 1'b0;
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        set_pix(274, 200, 24'h0);
        #1 chk("corner_rom_x", bus.rom_x, 0);
        chk("corner_rom_y", bus.rom_y, 0);
        chk("corner_type",  bus.rom_type, 0);
        tick();
        set_pix(365, 241, 24'hFF8000);
        #1 chk("corner_valid", bus.out_valid, 1);
        chk("corner_rgb",   bus.out_rgb, 24'hFF8000);
        chk("far_rom_x",    bus.rom_x, 91);
        chk("far_rom_y",    bus.rom_y, 41);
        tick();
        scan_points();
        repeat (2) frame();
        bus.frame_start = 1'b1;
        set_pix(0, 0, 24'h0);
        tick();
        bus.frame_start = 1'b0;
        #1 chk("hold_done_idle", bus.busy, 0);
        scan_points();

        // Type 3 clamps; a second request while busy is held off.
        bus.req_valid = 1'b1; bus.req_buff_type = 2'd3;
        tick();
        #1 chk("clamp_type", bus.rom_type, 2);
        bus.req_buff_type = 2'd1;
        #1 chk("busy_ready", bus.req_ready, 0);
        tick();
        #1 chk("type_kept", bus.rom_type, 2);
        bus.req_valid   = 1'b0;
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        set_pix(300, 220, 24'h00FF00);
        tick();
        #1 chk("pre_cancel_valid", bus.out_valid, 1);
        bus.cancel = 1'b1; bus.frame_start = 1'b1;
        tick();
        bus.cancel = 1'b0; bus.frame_start = 1'b0;
        #1 chk("cancel_idle",  bus.busy, 0);
        chk("cancel_flush", bus.out_valid, 0);
        repeat (3) tick();

        // Asynchronous reset while the panel is on screen.
        bus.req_valid = 1'b1; bus.req_buff_type = 2'd2;
        tick();
        bus.req_valid   = 1'b0;
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        set_pix(320, 220, 24'h0000FF);
        tick();
        #1 chk("pre_rst_valid", bus.out_valid, 1);
        #1 rst_n = 1'b0;
        #1 chk("arst_out_valid", bus.out_valid, 0);
        chk("arst_out_rgb", bus.out_rgb, 0);
        chk("arst_busy",    bus.busy, 0);
        tick();
        rst_n = 1'b1;
        tick();
        #1 chk("post_rst_ready", bus.req_ready, 1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
